detector_jogada: RTL and testbench

- Input stage feeding the game datapath and control unit of circuito_exp6.
- Conditions the 4 raw player buttons: synchronizes, debounces, and validates one-hot.
- Emits a single-cycle `tem_jogada` event plus a registered 4-bit `jogada` code.
- Replaces the raw OR-of-buttons play detection; the control unit consumes `tem_jogada`, the comparator consumes `jogada`.

---
 rtl/detector_jogada.sv | 170 +++++++++++++++++
 tb/tb_detector_jogada.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/detector_jogada.sv
// Player-button input stage: 2-flop synchronizer, press/release debounce FSM, one-hot check.
// Optional DETECTOR_JOGADA_RELEASE_EN moves the play event from the press to the debounced release.
module detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    input  logic       limpa,
    output logic [3:0] jogada,
    output logic       tem_jogada,
    output logic       invalida,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO      = 3'b000,
        FILTRA      = 3'b001,
        ACEITA      = 3'b010,
        PRESSIONADO = 3'b011,
`ifdef DETECTOR_JOGADA_RELEASE_EN
        SOLTA       = 3'b100,
        EMITE       = 3'b101
`else
        SOLTA       = 3'b100
`endif
    } estado_t;

    localparam logic [CNT_W-1:0] LIMITE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] UM     = CNT_W'(1);

    function automatic logic eh_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] incr_sat(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + UM;
    endfunction

    logic [3:0]       sinc;
    logic [3:0]       b_s;
    estado_t          estado, estado_prox;
    logic [CNT_W-1:0] cnt, cnt_prox;
    logic [3:0]       amostra, amostra_prox;
    logic             evento;
    logic             hab_evento;

    always_ff @(posedge clock) begin
        if (reset) begin
            sinc <= 4'b0000;
            b_s  <= 4'b0000;
        end else begin
            sinc <= botoes;
            b_s  <= sinc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
            cnt    <= '0;
        end else begin
            estado <= estado_prox;
            cnt    <= cnt_prox;
        end
        amostra <= amostra_prox;
    end

    always_comb begin
        estado_prox  = estado;
        cnt_prox     = cnt;
        amostra_prox = amostra;
        case (estado)
            OCIOSO: begin
                if (b_s != 4'b0000) begin
                    amostra_prox = b_s;
                    cnt_prox     = UM;
                    estado_prox  = FILTRA;
                end
            end
            FILTRA: begin
                if (b_s == 4'b0000) begin
                    estado_prox = OCIOSO;
                end else if (b_s != amostra) begin
                    // Pattern changed mid-filter: restart the count on the new sample.
                    amostra_prox = b_s;
                    cnt_prox     = UM;
                end else if (cnt >= LIMITE) begin
                    estado_prox = ACEITA;
                end else begin
                    cnt_prox = incr_sat(cnt);
                end
            end
            ACEITA: begin
                estado_prox = PRESSIONADO;
            end
            PRESSIONADO: begin
                if (b_s == 4'b0000) begin
                    cnt_prox    = UM;
                    estado_prox = SOLTA;
                end
            end
            SOLTA: begin
                if (b_s != 4'b0000) begin
                    estado_prox = PRESSIONADO;
                end else if (cnt >= LIMITE) begin
`ifdef DETECTOR_JOGADA_RELEASE_EN
                    estado_prox = EMITE;
`else
                    estado_prox = OCIOSO;
`endif
                end else begin
                    cnt_prox = incr_sat(cnt);
                end
            end
`ifdef DETECTOR_JOGADA_RELEASE_EN
            EMITE: begin
                estado_prox = OCIOSO;
            end
`endif
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

`ifdef DETECTOR_JOGADA_RELEASE_EN
    logic habilita_amostra;

    // habilita is captured at acceptance time and applied when the release completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            habilita_amostra <= 1'b0;
        end else if (estado == ACEITA) begin
            habilita_amostra <= habilita;
        end
    end

    assign evento     = (estado == EMITE);
    assign hab_evento = habilita_amostra;
`else
    assign evento     = (estado == ACEITA);
    assign hab_evento = habilita;
`endif

    always_comb begin
        tem_jogada = 1'b0;
        invalida   = 1'b0;
        db_estado  = estado;
        if (evento && hab_evento) begin
            tem_jogada = eh_one_hot(amostra);
            invalida   = !eh_one_hot(amostra);
        end
    end

    // A load in the event cycle takes priority over a coincident clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            jogada <= 4'b0000;
        end else if (tem_jogada) begin
            jogada <= amostra;
        end else if (limpa) begin
            jogada <= 4'b0000;
        end
    end

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada: latency, long hold, glitch, invalid press, release bounce, reset, limpa.
module tb_detector_jogada;

    logic       clock;
    logic       reset;
    logic [3:0] botoes;
    logic       habilita;
    logic       limpa;
    logic [3:0] jogada;
    logic       tem_jogada;
    logic       invalida;
    logic [2:0] db_estado;

    int n_chk = 0;
    int n_ok  = 0;
    int tem_cnt = 0;
    int inv_cnt = 0;
    int ambos_cnt = 0;

    detector_jogada #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .botoes     (botoes),
        .habilita   (habilita),
        .limpa      (limpa),
        .jogada     (jogada),
        .tem_jogada (tem_jogada),
        .invalida   (invalida),
        .db_estado  (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (tem_jogada) tem_cnt++;
        if (invalida) inv_cnt++;
        if (tem_jogada && invalida) ambos_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int t0;
        int i0;
        int ruim;

        reset = 1'b1; botoes = 4'b0000; habilita = 1'b1; limpa = 1'b0;
        tick(2);
        chk("rst_db", db_estado, 0);
        chk("rst_jogada", jogada, 0);
        chk("rst_tem", tem_jogada, 0);
        chk("rst_inv", invalida, 0);
        reset = 1'b0;
        tick(1);

        // Single valid press: pulse exactly in the 7th cycle after driving
        t0 = tem_cnt; i0 = inv_cnt;
        botoes = 4'b0001;
        tick(6);
        chk("t1_tem_early", tem_jogada, 0);
        tick(1);
        chk("t1_tem_pulse", tem_jogada, 1);
        chk("t1_db_aceita", db_estado, 2);
        tick(1);
        chk("t1_tem_after", tem_jogada, 0);
        chk("t1_jogada", jogada, 1);
        chk("t1_db_press", db_estado, 3);
        tick(2);
        botoes = 4'b0000;
        tick(7);
        chk("t1_db_idle", db_estado, 0);
        chk("t1_jogada_held", jogada, 1);
        chk("t1_tem_count", tem_cnt - t0, 1);
        chk("t1_inv_count", inv_cnt - i0, 0);

        // Long hold: one event only, PRESSIONADO throughout
        t0 = tem_cnt;
        botoes = 4'b0100;
        tick(8);
        ruim = 0;
        for (int i = 0; i < 2990; i++) begin
            tick(1);
            if (db_estado != 3'b011) ruim++;
        end
        chk("t2_hold_state", ruim, 0);
        botoes = 4'b0000;
        tick(6);
        chk("t2_db_solta", db_estado, 4);
        tick(1);
        chk("t2_db_idle", db_estado, 0);
        chk("t2_tem_count", tem_cnt - t0, 1);
        chk("t2_jogada", jogada, 4);

        // Short glitches never reach the filter limit
        t0 = tem_cnt;
        botoes = 4'b0010; tick(2);
        botoes = 4'b0000; tick(1);
        botoes = 4'b0010; tick(2);
        botoes = 4'b0000; tick(8);
        chk("t3_glitch_count", tem_cnt - t0, 0);
        chk("t3_glitch_jogada", jogada, 4);
        chk("t3_glitch_db", db_estado, 0);
        botoes = 4'b0010; tick(10);
        botoes = 4'b0000; tick(8);
        chk("t3_tem_count", tem_cnt - t0, 1);
        chk("t3_jogada", jogada, 2);

        // Multi-button press flags invalida; disabled press is silent
        t0 = tem_cnt; i0 = inv_cnt;
        botoes = 4'b0011;
        tick(7);
        chk("t4_inv_pulse", invalida, 1);
        chk("t4_tem_low", tem_jogada, 0);
        tick(3);
        botoes = 4'b0000; tick(8);
        chk("t4_inv_count", inv_cnt - i0, 1);
        chk("t4_tem_count", tem_cnt - t0, 0);
        chk("t4_jogada_kept", jogada, 2);
        t0 = tem_cnt; i0 = inv_cnt;
        habilita = 1'b0;
        botoes = 4'b1000; tick(10);
        botoes = 4'b0000; tick(8);
        chk("t4_dis_tem", tem_cnt - t0, 0);
        chk("t4_dis_inv", inv_cnt - i0, 0);
        chk("t4_dis_jogada", jogada, 2);
        habilita = 1'b1;

        // Release bounce keeps the detector in the pressed phase
        t0 = tem_cnt;
        botoes = 4'b0001; tick(10);
        chk("t5_jogada1", jogada, 1);
        botoes = 4'b0000; tick(2);
        botoes = 4'b0001; tick(1);
        botoes = 4'b0000; tick(2);
        botoes = 4'b1000; tick(10);
        chk("t5_db_press", db_estado, 3);
        chk("t5_jogada_still1", jogada, 1);
        chk("t5_count_one", tem_cnt - t0, 1);
        botoes = 4'b0000; tick(8);
        chk("t5_db_idle", db_estado, 0);
        botoes = 4'b1000; tick(10);
        botoes = 4'b0000; tick(8);
        chk("t5_jogada8", jogada, 8);
        chk("t5_count_two", tem_cnt - t0, 2);

        // Reset while filtering
        t0 = tem_cnt;
        botoes = 4'b0100; tick(4);
        chk("t6_db_filtra", db_estado, 1);
        reset = 1'b1; botoes = 4'b0000;
        tick(1);
        chk("t6_rst_db", db_estado, 0);
        chk("t6_rst_jogada", jogada, 0);
        chk("t6_rst_tem", tem_jogada, 0);
        chk("t6_rst_inv", invalida, 0);
        reset = 1'b0;
        tick(10);
        chk("t6_no_event", tem_cnt - t0, 0);

        // limpa coinciding with a load: load wins; alone it clears without touching state
        botoes = 4'b0010; tick(7);
        chk("t6_aceita", tem_jogada, 1);
        limpa = 1'b1; tick(1); limpa = 1'b0;
        chk("t6_load_wins", jogada, 2);
        limpa = 1'b1; tick(1); limpa = 1'b0;
        chk("t6_limpa_clear", jogada, 0);
        chk("t6_limpa_state", db_estado, 3);
        botoes = 4'b0000; tick(8);
        chk("t6_final_idle", db_estado, 0);

        chk("exclusive_pulses", ambos_cnt, 0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
